// File: rtl/plab5_mcore_mem_req_xbar_sec_pkg.sv
// Shared widths and routing helpers for the domain-aware memory request crossbar.
// No logic of its own; imported by the crossbar and its arbiter.
// Widths follow the vc mem request layout {type, opaque, addr, len, data}.
package plab5_mcore_mem_req_xbar_sec_pkg;

    function automatic int req_msg_nbits(input int o, input int a, input int d);
        return 3 + o + a + $clog2(d / 8) + d;
    endfunction

    function automatic int out_msg_nbits(input int rq, input int ns);
        return rq + ns + 1;
    endfunction

    // LSB position of the address field inside a request message
    function automatic int addr_lsb(input int d);
        return $clog2(d / 8) + d;
    endfunction

    // 16-byte line interleave: line_idx is addr[6:4]
    function automatic int dest_of(input logic [2:0] line_idx, input int ns, input bit single);
        if (single) return 0;
        return int'(line_idx) & ((1 << ns) - 1);
    endfunction

endpackage

// File: rtl/plab5_mcore_mem_req_xbar_sec_fifo.sv
// Generic circular FIFO, registered storage, no bypass.
// Latency: entry visible at the head the cycle after enqueue.
// Backpressure: enq_rdy low when full even if a dequeue happens that cycle.
module plab5_mcore_mem_req_xbar_sec_fifo #(
    parameter int p_width = 8,
    parameter int p_depth = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_vld,
    output logic               enq_rdy,
    input  logic [p_width-1:0] enq_dat,
    output logic               deq_vld,
    input  logic               deq_rdy,
    output logic [p_width-1:0] deq_dat
);
    localparam int AW = $clog2(p_depth);
    localparam int CW = AW + 1;

    logic [p_width-1:0] mem_q [p_depth];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               enq, deq;

    always_comb begin
        enq_rdy  = (cnt_q != CW'(p_depth));
        deq_vld  = (cnt_q != '0);
        enq      = enq_vld && enq_rdy;
        deq      = deq_vld && deq_rdy;
        wr_ptr_d = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(enq) - CW'(deq);
        deq_dat  = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= enq_dat;
    end

endmodule

// File: rtl/plab5_mcore_mem_xbar_rr_arb.sv
// Round-robin arbiter for one bank lane; pointer moves only on a completed transfer.
// Latency: combinational grant from req and registered state.
// Backpressure: a stalled grant is held while its requester stays eligible.
module plab5_mcore_mem_xbar_rr_arb #(
    parameter  int p_num_reqs = 4,
    localparam int NS         = $clog2(p_num_reqs)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [p_num_reqs-1:0] req,
    input  logic                  out_rdy,
    output logic                  gnt_vld,
    output logic [NS-1:0]         gnt_idx,
    output logic [p_num_reqs-1:0] gnt
);
    logic [NS-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d;
    logic          lock_vld_q, lock_vld_d;
    logic [NS-1:0] idx;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        // Keep a stalled winner so the lane message cannot change before transfer
        if (lock_vld_q && req[lock_idx_q]) begin
            gnt_vld = 1'b1;
            gnt_idx = lock_idx_q;
        end else begin
            for (int k = 0; k < p_num_reqs; k++) begin
                idx = ptr_q + NS'(k);
                if (!gnt_vld && req[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
        gnt        = gnt_vld ? (p_num_reqs'(1) << gnt_idx) : '0;
        ptr_d      = (gnt_vld && out_rdy) ? gnt_idx + NS'(1) : ptr_q;
        lock_vld_d = gnt_vld && !out_rdy;
        lock_idx_d = gnt_idx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: rtl/plab5_mcore_mem_req_xbar_sec.sv
// N-port domain-aware memory request crossbar: per-core queues, per-bank RR arbiters, secure TDM.
// Latency: 1 cycle from input acceptance to bank output; 1 request per bank per cycle.
// Backpressure: req_in_rdy = queue not full; bank rdy low holds the grant (may withdraw at a slot edge in secure mode).
module plab5_mcore_mem_req_xbar_sec
    import plab5_mcore_mem_req_xbar_sec_pkg::*;
#(
    parameter  int p_mem_opaque_nbits = 8,
    parameter  int p_mem_addr_nbits   = 32,
    parameter  int p_mem_data_nbits   = 32,
    parameter  int p_num_ports        = 4,
    parameter  int p_queue_depth      = 2,
    parameter  int p_slot_cycles      = 4,
    parameter  int p_single_bank      = 0,
    localparam int RQ = req_msg_nbits(p_mem_opaque_nbits, p_mem_addr_nbits, p_mem_data_nbits),
    localparam int NS = $clog2(p_num_ports),
    localparam int OM = out_msg_nbits(RQ, NS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [p_num_ports-1:0]    bank_domain,
    input  logic [p_num_ports*RQ-1:0] req_in_msg,
    input  logic [p_num_ports-1:0]    req_in_domain,
    input  logic [p_num_ports-1:0]    req_in_val,
    output logic [p_num_ports-1:0]    req_in_rdy,
    output logic [p_num_ports*OM-1:0] req_out_msg,
    output logic [p_num_ports-1:0]    req_out_val,
    input  logic [p_num_ports-1:0]    req_out_rdy,
    output logic                      viol_pulse,
    output logic [15:0]               viol_count
);
    localparam int QW   = RQ + 1;
    localparam int ALSB = addr_lsb(p_mem_data_nbits);
    localparam int SW   = $clog2(p_slot_cycles) + 1;

    logic [p_num_ports-1:0] q_deq_vld, q_deq_rdy, drop, ok;
    logic [QW-1:0]          q_head   [p_num_ports];
    logic [NS-1:0]          head_dst [p_num_ports];
    logic [p_num_ports-1:0] head_dom;
    logic [p_num_ports-1:0] bank_req [p_num_ports];
    logic [p_num_ports-1:0] gnt_oh   [p_num_ports];
    logic [NS-1:0]          gnt_idx  [p_num_ports];

    logic [SW-1:0] slot_cyc_q, slot_cyc_d;
    logic          slot_dom_q, slot_dom_d;
    logic [15:0]   viol_count_q, viol_count_d;
    logic [16:0]   viol_sum;
    int            n_drop;

    for (genvar i = 0; i < p_num_ports; i++) begin : g_q
        plab5_mcore_mem_req_xbar_sec_fifo #(.p_width(QW), .p_depth(p_queue_depth)) u_q (
            .clk     (clk),
            .reset   (reset),
            .enq_vld (req_in_val[i]),
            .enq_rdy (req_in_rdy[i]),
            .enq_dat ({req_in_domain[i], req_in_msg[i*RQ +: RQ]}),
            .deq_vld (q_deq_vld[i]),
            .deq_rdy (q_deq_rdy[i]),
            .deq_dat (q_head[i])
        );
    end

    always_comb begin
        for (int i = 0; i < p_num_ports; i++) begin
            head_dom[i] = q_head[i][RQ];
            head_dst[i] = NS'(dest_of(q_head[i][ALSB+4 +: 3], NS, p_single_bank != 0));
            // Wrong-domain heads never compete; they are discarded on sight
            drop[i] = mode && q_deq_vld[i] && (head_dom[i] != bank_domain[head_dst[i]]);
            ok[i]   = q_deq_vld[i] && !drop[i] && (!mode || head_dom[i] == slot_dom_q);
        end
        for (int b = 0; b < p_num_ports; b++) begin
            for (int i = 0; i < p_num_ports; i++) begin
                bank_req[b][i] = ok[i] && (head_dst[i] == NS'(b));
            end
        end
    end

    for (genvar b = 0; b < p_num_ports; b++) begin : g_arb
        plab5_mcore_mem_xbar_rr_arb #(.p_num_reqs(p_num_ports)) u_arb (
            .clk     (clk),
            .reset   (reset),
            .req     (bank_req[b]),
            .out_rdy (req_out_rdy[b]),
            .gnt_vld (req_out_val[b]),
            .gnt_idx (gnt_idx[b]),
            .gnt     (gnt_oh[b])
        );
    end

    always_comb begin
        req_out_msg = '0;
        for (int b = 0; b < p_num_ports; b++) begin
            if (req_out_val[b]) req_out_msg[b*OM +: OM] = {gnt_idx[b], q_head[gnt_idx[b]]};
        end
        n_drop = 0;
        for (int i = 0; i < p_num_ports; i++) begin
            q_deq_rdy[i] = drop[i];
            for (int b = 0; b < p_num_ports; b++) begin
                if (gnt_oh[b][i] && req_out_rdy[b]) q_deq_rdy[i] = 1'b1;
            end
            if (drop[i]) n_drop = n_drop + 1;
        end
        viol_pulse   = |drop;
        viol_sum     = {1'b0, viol_count_q} + 17'(n_drop);
        viol_count_d = viol_sum[16] ? 16'hFFFF : viol_sum[15:0];
        // Slot timer free-runs in both modes so secure entry lands on a known phase
        if (slot_cyc_q == SW'(p_slot_cycles - 1)) begin
            slot_cyc_d = '0;
            slot_dom_d = ~slot_dom_q;
        end else begin
            slot_cyc_d = slot_cyc_q + SW'(1);
            slot_dom_d = slot_dom_q;
        end
    end

    assign viol_count = viol_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cyc_q   <= '0;
            slot_dom_q   <= 1'b0;
            viol_count_q <= '0;
        end else begin
            slot_cyc_q   <= slot_cyc_d;
            slot_dom_q   <= slot_dom_d;
            viol_count_q <= viol_count_d;
        end
    end

endmodule

// File: tb/tb_plab5_mcore_mem_req_xbar_sec.sv
// Bench for the secure memory request crossbar: directed scenarios plus a randomized run
// checked against a queue-level model of routing, drop, TDM and round-robin rules.
module tb_plab5_mcore_mem_req_xbar_sec;
    localparam int N     = 4;
    localparam int NS    = 2;
    localparam int DEPTH = 2;
    localparam int SLOT  = 4;
    localparam int RQ    = 3 + 8 + 32 + 2 + 32;
    localparam int OM    = RQ + NS + 1;
    localparam int ALSB  = 34;

    typedef logic [RQ:0] ent_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            mode;
    logic [N-1:0]    bank_domain;
    logic [N*RQ-1:0] req_in_msg;
    logic [N-1:0]    req_in_domain, req_in_val, req_in_rdy;
    logic [N*OM-1:0] req_out_msg;
    logic [N-1:0]    req_out_val, req_out_rdy;
    logic            viol_pulse;
    logic [15:0]     viol_count;

    int n_tests = 0;
    int n_fail  = 0;

    plab5_mcore_mem_req_xbar_sec dut (
        .clk           (clk),
        .reset         (reset),
        .mode          (mode),
        .bank_domain   (bank_domain),
        .req_in_msg    (req_in_msg),
        .req_in_domain (req_in_domain),
        .req_in_val    (req_in_val),
        .req_in_rdy    (req_in_rdy),
        .req_out_msg   (req_out_msg),
        .req_out_val   (req_out_val),
        .req_out_rdy   (req_out_rdy),
        .viol_pulse    (viol_pulse),
        .viol_count    (viol_count)
    );

    always #5 clk = ~clk;

    function automatic logic [OM-1:0] lane(input int b);
        return req_out_msg[b*OM +: OM];
    endfunction

    function automatic logic [RQ-1:0] mk_msg(input logic [31:0] addr);
        return {3'($urandom), 8'($urandom), addr, 2'($urandom), 32'($urandom)};
    endfunction

    task automatic drive(input int i, input logic dom, input logic [RQ-1:0] m);
        req_in_val[i]          = 1'b1;
        req_in_domain[i]       = dom;
        req_in_msg[i*RQ +: RQ] = m;
    endtask

    task automatic do_reset();
        mode = 1'b0; bank_domain = '0; req_in_msg = '0; req_in_domain = '0;
        req_in_val = '0; req_out_rdy = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++; if (req_in_rdy !== 4'hF) begin n_fail++; $display("FAIL reset_in_rdy got %h want f", req_in_rdy); end
        n_tests++; if (req_out_val !== 4'h0) begin n_fail++; $display("FAIL reset_out_val got %h want 0", req_out_val); end
        n_tests++; if (req_out_msg !== '0) begin n_fail++; $display("FAIL reset_out_msg got %h want 0", req_out_msg); end
        n_tests++; if (viol_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_viol_pulse got %b want 0", viol_pulse); end
        n_tests++; if (viol_count !== 16'h0) begin n_fail++; $display("FAIL reset_viol_count got %h want 0", viol_count); end
    endtask

    task automatic test_route();
        logic [RQ-1:0] m0, m1;
        m0 = mk_msg(32'h10); m1 = mk_msg(32'h20);
        mode = 1'b0; req_out_rdy = 4'hF;
        drive(0, 1'b0, m0); drive(1, 1'b0, m1);
        @(negedge clk); req_in_val = '0; #1;
        n_tests++; if (req_out_val !== 4'b0110) begin n_fail++; $display("FAIL route_val got %b want 0110", req_out_val); end
        n_tests++; if (lane(1) !== {2'd0, 1'b0, m0}) begin n_fail++; $display("FAIL route_lane1 got %h want %h", lane(1), {2'd0, 1'b0, m0}); end
        n_tests++; if (lane(2) !== {2'd1, 1'b0, m1}) begin n_fail++; $display("FAIL route_lane2 got %h want %h", lane(2), {2'd1, 1'b0, m1}); end
        @(negedge clk); #1;
        n_tests++; if (req_out_val !== 4'b0000) begin n_fail++; $display("FAIL route_drain got %b want 0000", req_out_val); end
    endtask

    task automatic test_rr_order();
        logic [RQ-1:0] m [N];
        req_out_rdy = 4'b1000;
        for (int k = 0; k < N; k++) begin
            m[k] = mk_msg(32'h30);
            drive(k, 1'b0, m[k]);
        end
        @(negedge clk); req_in_val = '0;
        for (int k = 0; k < N; k++) begin
            #1;
            n_tests++; if (req_out_val[3] !== 1'b1 || lane(3) !== {NS'(k), 1'b0, m[k]}) begin
                n_fail++; $display("FAIL rr_grant%0d got val=%b lane=%h want lane=%h", k, req_out_val[3], lane(3), {NS'(k), 1'b0, m[k]});
            end
            @(negedge clk);
        end
        #1;
        n_tests++; if (req_out_val !== 4'b0000) begin n_fail++; $display("FAIL rr_done got %b want 0000", req_out_val); end
    endtask

    task automatic test_backpressure();
        logic [RQ-1:0] ma, mb;
        ma = mk_msg(32'h10); mb = mk_msg(32'h10);
        @(negedge clk);
        req_out_rdy = 4'h0;
        drive(0, 1'b0, ma);
        @(negedge clk); drive(0, 1'b0, mb);
        @(negedge clk); req_in_val = '0; #1;
        n_tests++; if (req_in_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL bp_full got %b want 0", req_in_rdy[0]); end
        n_tests++; if (req_out_val[1] !== 1'b1 || lane(1) !== {2'd0, 1'b0, ma}) begin
            n_fail++; $display("FAIL bp_hold got val=%b lane=%h want %h", req_out_val[1], lane(1), {2'd0, 1'b0, ma});
        end
        req_out_rdy = 4'hF;
        @(negedge clk); #1;
        n_tests++; if (req_out_val[1] !== 1'b1 || lane(1) !== {2'd0, 1'b0, mb}) begin
            n_fail++; $display("FAIL bp_second got val=%b lane=%h want %h", req_out_val[1], lane(1), {2'd0, 1'b0, mb});
        end
        n_tests++; if (req_in_rdy[0] !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_back got %b want 1", req_in_rdy[0]); end
        @(negedge clk); #1;
        n_tests++; if (req_out_val !== 4'b0000) begin n_fail++; $display("FAIL bp_drained got %b want 0000", req_out_val); end
    endtask

    task automatic test_tdm();
        logic [RQ-1:0] m;
        m = mk_msg(32'h20);
        do_reset();
        mode = 1'b1; bank_domain = 4'hF; req_out_rdy = 4'hF;
        drive(0, 1'b1, m);
        @(negedge clk); req_in_val = '0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            n_tests++; if (req_out_val !== 4'b0000) begin n_fail++; $display("FAIL tdm_idle_c%0d got %b want 0000", c, req_out_val); end
            @(negedge clk);
        end
        #1;
        n_tests++; if (req_out_val !== 4'b0100 || lane(2) !== {2'd0, 1'b1, m}) begin
            n_fail++; $display("FAIL tdm_slot1 got val=%b lane=%h want val=0100 lane=%h", req_out_val, lane(2), {2'd0, 1'b1, m});
        end
        @(negedge clk); #1;
        n_tests++; if (req_out_val !== 4'b0000) begin n_fail++; $display("FAIL tdm_after got %b want 0000", req_out_val); end
    endtask

    task automatic test_drop();
        bank_domain = 4'h0; mode = 1'b1; req_out_rdy = 4'hF;
        drive(0, 1'b1, mk_msg(32'h20));
        @(negedge clk); req_in_val = '0; #1;
        n_tests++; if (viol_pulse !== 1'b1) begin n_fail++; $display("FAIL drop_pulse got %b want 1", viol_pulse); end
        n_tests++; if (req_out_val !== 4'b0000) begin n_fail++; $display("FAIL drop_val got %b want 0000", req_out_val); end
        @(negedge clk); #1;
        n_tests++; if (viol_pulse !== 1'b0) begin n_fail++; $display("FAIL drop_pulse_end got %b want 0", viol_pulse); end
        n_tests++; if (viol_count !== 16'd1) begin n_fail++; $display("FAIL drop_count got %0d want 1", viol_count); end
        n_tests++; if (req_out_val !== 4'b0000) begin n_fail++; $display("FAIL drop_val_end got %b want 0000", req_out_val); end
    endtask

    task automatic test_reset_mid();
        mode = 1'b0; req_out_rdy = 4'h0;
        drive(0, 1'b0, mk_msg(32'h10));
        @(negedge clk); drive(0, 1'b0, mk_msg(32'h10));
        @(negedge clk); req_in_val = '0; #1;
        n_tests++; if (req_in_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_pre got %b want 0", req_in_rdy[0]); end
        #1 reset = 1'b0;
        #1;
        n_tests++; if (req_out_val !== 4'b0000) begin n_fail++; $display("FAIL rmid_val got %b want 0000", req_out_val); end
        n_tests++; if (req_in_rdy !== 4'hF) begin n_fail++; $display("FAIL rmid_rdy got %h want f", req_in_rdy); end
        n_tests++; if (viol_count !== 16'h0) begin n_fail++; $display("FAIL rmid_count got %0d want 0", viol_count); end
        @(negedge clk); reset = 1'b1; req_out_rdy = 4'hF; #1;
        n_tests++; if (req_out_val !== 4'b0000 || req_in_rdy !== 4'hF) begin
            n_fail++; $display("FAIL rmid_release got val=%b rdy=%h want 0000/f", req_out_val, req_in_rdy);
        end
    endtask

    // Model state for the randomized run
    ent_t mq [N][$];
    int   mptr [N];
    bit   held_v [N];
    int   held_src [N];
    int   m_cyc, m_slot, m_viol;

    task automatic test_random();
        int   hdst [N];
        bit   hv [N], hd [N], mdrop [N], mok [N];
        int   win [N];
        logic [N-1:0] exp_val, exp_rdy;
        logic [OM-1:0] exp_lane;
        logic [31:0] haddr;
        bit   exp_pulse;
        int   ndrop;
        do_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete(); mptr[i] = 0; held_v[i] = 0; held_src[i] = 0;
        end
        m_cyc = 0; m_slot = 0; m_viol = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) bank_domain = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                req_in_val[i]          = ($urandom_range(0, 2) != 0);
                req_in_domain[i]       = 1'($urandom);
                req_in_msg[i*RQ +: RQ] = mk_msg($urandom);
                req_out_rdy[i]         = ($urandom_range(0, 3) != 0);
            end
            #1;
            exp_pulse = 0;
            for (int i = 0; i < N; i++) begin
                hv[i] = mq[i].size() > 0;
                hd[i] = 0; hdst[i] = 0;
                if (hv[i]) begin
                    hd[i]   = mq[i][0][RQ];
                    haddr   = mq[i][0][ALSB +: 32];
                    hdst[i] = (haddr / 16) % N;
                end
                mdrop[i] = mode && hv[i] && (hd[i] != bank_domain[hdst[i]]);
                mok[i]   = hv[i] && !mdrop[i] && (!mode || hd[i] == (m_slot % 2));
                exp_rdy[i] = mq[i].size() < DEPTH;
                if (mdrop[i]) exp_pulse = 1;
            end
            for (int b = 0; b < N; b++) begin
                win[b] = -1;
                if (held_v[b] && mok[held_src[b]] && hdst[held_src[b]] == b) win[b] = held_src[b];
                else for (int k = 0; k < N; k++) begin
                    int j;
                    j = (mptr[b] + k) % N;
                    if (win[b] < 0 && mok[j] && hdst[j] == b) win[b] = j;
                end
                exp_val[b] = win[b] >= 0;
            end
            n_tests++; if (req_out_val !== exp_val) begin n_fail++; $display("FAIL rand_val c%0d got %b want %b", cyc, req_out_val, exp_val); end
            for (int b = 0; b < N; b++) begin
                exp_lane = (win[b] >= 0) ? {NS'(win[b]), mq[win[b]][0]} : '0;
                n_tests++; if (lane(b) !== exp_lane) begin n_fail++; $display("FAIL rand_lane%0d c%0d got %h want %h", b, cyc, lane(b), exp_lane); end
            end
            n_tests++; if (req_in_rdy !== exp_rdy) begin n_fail++; $display("FAIL rand_in_rdy c%0d got %b want %b", cyc, req_in_rdy, exp_rdy); end
            n_tests++; if (viol_pulse !== exp_pulse) begin n_fail++; $display("FAIL rand_pulse c%0d got %b want %b", cyc, viol_pulse, exp_pulse); end
            n_tests++; if (viol_count !== 16'(m_viol)) begin n_fail++; $display("FAIL rand_count c%0d got %0d want %0d", cyc, viol_count, m_viol); end
            ndrop = 0;
            for (int i = 0; i < N; i++) if (mdrop[i]) begin void'(mq[i].pop_front()); ndrop++; end
            for (int b = 0; b < N; b++) begin
                if (win[b] >= 0 && req_out_rdy[b]) begin
                    void'(mq[win[b]].pop_front());
                    mptr[b] = (win[b] + 1) % N;
                end
                held_v[b]   = (win[b] >= 0) && !req_out_rdy[b];
                held_src[b] = (win[b] >= 0) ? win[b] : 0;
            end
            for (int i = 0; i < N; i++)
                if (req_in_val[i] && exp_rdy[i]) mq[i].push_back({req_in_domain[i], req_in_msg[i*RQ +: RQ]});
            m_viol = (m_viol + ndrop > 65535) ? 65535 : m_viol + ndrop;
            m_cyc++;
            if (m_cyc == SLOT) begin m_cyc = 0; m_slot++; end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_route();
        test_rr_order();
        test_backpressure();
        test_tdm();
        test_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
